// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The rxd line is synchronised, a start edge is detected, and each bit is
// decided by a 3-sample majority vote around mid-bit. Each received byte is
// reported with a one-cycle uart_done pulse, and uart_data holds that byte.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       uart_frame_err,
  output logic       uart_rx_busy
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned MID_CNT = BPS_CNT / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_rxd_s1;
  logic             r_rxd_s;
  logic             r_rxd_d;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       r_samp;
  logic [7:0]       r_shift;
  logic             w_fall;
  logic             w_wrap;
  logic             w_decide;
  logic             w_samp_en;
  logic             w_bit;
  logic             w_done;
  logic             w_err;

  assign w_fall    = r_rxd_d & ~r_rxd_s;
  assign w_wrap    = (r_clk_cnt == CNT_W'(BPS_CNT - 1));
  assign w_decide  = (r_clk_cnt == CNT_W'(MID_CNT + 2));
  assign w_samp_en = (r_clk_cnt >= CNT_W'(MID_CNT - 1)) && (r_clk_cnt <= CNT_W'(MID_CNT + 1));
  assign w_bit     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

  // Two-flop synchroniser plus delay flop for edge detection; idle line is high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s  <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s  <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s;
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state decode and the single-cycle done/error strobes.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_fall) w_next = S_START;
      S_START: begin
        if (w_decide && w_bit) w_next = S_IDLE;
        else if (w_wrap)       w_next = S_DATA;
      end
      S_DATA:  if (w_wrap && (r_bit_cnt == 3'd7)) w_next = S_STOP;
      S_STOP: begin
        if (w_decide) begin
          if (w_bit) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_err  = 1'b1;
            w_next = S_BREAK;
          end
        end
      end
      S_BREAK: if (r_rxd_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bit timing, majority sampling and the LSB-first shift register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_samp    <= '0;
      r_shift   <= '0;
    end else begin
      if ((r_state == S_IDLE) || (r_state == S_BREAK)) r_clk_cnt <= '0;
      else if (w_wrap)                                 r_clk_cnt <= '0;
      else                                             r_clk_cnt <= r_clk_cnt + CNT_W'(1);

      if ((r_state == S_START) && w_wrap)     r_bit_cnt <= '0;
      else if ((r_state == S_DATA) && w_wrap) r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_samp_en) r_samp <= {r_samp[1:0], r_rxd_s};

      if ((r_state == S_DATA) && w_decide) r_shift <= {w_bit, r_shift[7:1]};
    end
  end

  // Registered outputs; uart_data only changes on a good frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uart_data      <= '0;
      uart_done      <= 1'b0;
      uart_frame_err <= 1'b0;
      uart_rx_busy   <= 1'b0;
    end else begin
      if (w_done) uart_data <= r_shift;
      uart_done      <= w_done;
      uart_frame_err <= w_err;
      uart_rx_busy   <= (w_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 434 clocks per bit.
module tb_uart_rx;

  localparam int unsigned BPS = 434;
  localparam int unsigned MID = 217;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rxd  = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  logic [7:0] rx_q[$];
  int         d0;
  int         e0;

  uart_rx dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .uart_rxd      (uart_rxd),
    .uart_data     (uart_data),
    .uart_done     (uart_done),
    .uart_frame_err(uart_frame_err),
    .uart_rx_busy  (uart_rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (uart_done) begin
        done_cnt++;
        rx_q.push_back(uart_data);
      end
      if (uart_frame_err) err_cnt++;
      if (uart_done && uart_frame_err) both_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    uart_rxd = b;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    hold(1'b0, BPS);
    for (int i = 0; i < 8; i++) hold(d[i], BPS);
    hold(stop_bit, BPS);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (uart_rx_busy && (k < budget)) begin
      @(posedge sys_clk);
      #1;
      k++;
    end
    check_eq(tag, 32'(uart_rx_busy), 32'd0);
  endtask

  initial begin
    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    check_eq("rst_data", 32'(uart_data), 32'h00);
    check_eq("rst_done", 32'(uart_done), 32'd0);
    check_eq("rst_err",  32'(uart_frame_err), 32'd0);
    check_eq("rst_busy", 32'(uart_rx_busy), 32'd0);
    sys_rst_n = 1'b1;
    hold(1'b1, 20);

    // Single frame 0x55
    d0 = done_cnt; e0 = err_cnt; rx_q.delete();
    send_byte(8'h55, 1'b1);
    hold(1'b1, BPS);
    check_eq("t1_done_n", 32'(done_cnt - d0), 32'd1);
    check_eq("t1_data",   32'(uart_data), 32'h55);
    check_eq("t1_err_n",  32'(err_cnt - e0), 32'd0);
    check_eq("t1_busy",   32'(uart_rx_busy), 32'd0);

    // Back-to-back frames with no idle gap
    d0 = done_cnt; rx_q.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b1);
    hold(1'b1, BPS);
    check_eq("t2_done_n", 32'(done_cnt - d0), 32'd3);
    check_eq("t2_qsize",  32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check_eq("t2_b0", 32'(rx_q[0]), 32'h00);
      check_eq("t2_b1", 32'(rx_q[1]), 32'hFF);
      check_eq("t2_b2", 32'(rx_q[2]), 32'hA5);
    end

    // 100-clock low glitch on an idle line
    d0 = done_cnt; e0 = err_cnt;
    hold(1'b0, 50);
    check_eq("t3_busy_hi", 32'(uart_rx_busy), 32'd1);
    hold(1'b0, 50);
    uart_rxd = 1'b1;
    wait_idle("t3_busy_drop", 220);
    hold(1'b1, BPS);
    check_eq("t3_done_n", 32'(done_cnt - d0), 32'd0);
    check_eq("t3_err_n",  32'(err_cnt - e0), 32'd0);

    // Bad stop bit followed by a break, then a good frame
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h3C, 1'b0);
    hold(1'b0, 2000);
    check_eq("t4_err_n",    32'(err_cnt - e0), 32'd1);
    check_eq("t4_done_n",   32'(done_cnt - d0), 32'd0);
    check_eq("t4_data_hold", 32'(uart_data), 32'hA5);
    check_eq("t4_brk_busy", 32'(uart_rx_busy), 32'd1);
    hold(1'b1, BPS);
    check_eq("t4_brk_exit", 32'(uart_rx_busy), 32'd0);
    send_byte(8'h81, 1'b1);
    hold(1'b1, BPS);
    check_eq("t4_done2_n", 32'(done_cnt - d0), 32'd1);
    check_eq("t4_data2",   32'(uart_data), 32'h81);
    check_eq("t4_err2_n",  32'(err_cnt - e0), 32'd1);

    // 0xF0 with a single-clock inverted spike near mid of bit 3
    d0 = done_cnt;
    hold(1'b0, BPS);
    for (int i = 0; i < 3; i++) hold(1'b0, BPS);
    hold(1'b0, MID + 1);
    hold(1'b1, 1);
    hold(1'b0, BPS - MID - 2);
    for (int i = 4; i < 8; i++) hold(1'b1, BPS);
    hold(1'b1, BPS);
    hold(1'b1, BPS);
    check_eq("t5_done_n", 32'(done_cnt - d0), 32'd1);
    check_eq("t5_data",   32'(uart_data), 32'hF0);

    // Reset in the middle of bit 4, then a clean frame
    hold(1'b0, BPS);
    hold(1'b1, BPS); hold(1'b1, BPS); hold(1'b0, BPS); hold(1'b1, BPS);
    hold(1'b0, BPS / 2);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("t6_rst_data", 32'(uart_data), 32'h00);
    check_eq("t6_rst_done", 32'(uart_done), 32'd0);
    check_eq("t6_rst_err",  32'(uart_frame_err), 32'd0);
    check_eq("t6_rst_busy", 32'(uart_rx_busy), 32'd0);
    repeat (10) @(posedge sys_clk);
    #1;
    d0 = done_cnt; e0 = err_cnt;
    sys_rst_n = 1'b1;
    hold(1'b1, 2 * BPS);
    check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t6_no_err",  32'(err_cnt - e0), 32'd0);
    send_byte(8'h12, 1'b1);
    hold(1'b1, BPS);
    check_eq("t6_done_n", 32'(done_cnt - d0), 32'd1);
    check_eq("t6_data",   32'(uart_data), 32'h12);

    check_eq("done_err_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
